// File: rtl/train_sequencer_if.sv
// Command/status bundle between the train sequencer and its controller.
// The sequencer is the slave: it samples the level requests and drives status.
interface train_sequencer_if;
  logic        start;
  logic        speed_ok;
  logic        station;
  logic        estop;
  logic        estop_ack;
  logic [3:0]  present_state;
  logic [18:0] t_remaining;
  logic        timer_done;
  logic        motor_en;
  logic        brake;
  logic        door_open;

  modport master (
    output start, speed_ok, station, estop, estop_ack,
    input  present_state, t_remaining, timer_done, motor_en, brake, door_open
  );
  modport slave (
    input  start, speed_ok, station, estop, estop_ack,
    output present_state, t_remaining, timer_done, motor_en, brake, door_open
  );
endinterface

// File: rtl/train_sequencer.sv
// Station-cycle train controller: FSM plus millisecond prescaler and countdown
// for the timed states; actuator enables are registered from the next state.
module train_sequencer #(
  parameter int CLKS_PER_MS = 50000,
  parameter int T_BRAKE_MS  = 2000,
  parameter int T_DOOR_MS   = 1000,
  parameter int T_DEPART_MS = 2000
) (
  input  logic           clk,
  input  logic           rst_n,
  train_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE   = 4'b0000,
    ACCEL  = 4'b0001,
    CRUISE = 4'b0010,
    BRAKE  = 4'b0011,
    DOORS  = 4'b0100,
    DEPART = 4'b0101,
    ESTOP  = 4'b1111
  } state_e;

  localparam int            PW   = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [PW-1:0] PMAX = PW'(CLKS_PER_MS - 1);

  // Held as a raw code so that corrupted (unused) encodings remain representable.
  logic [3:0]    state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [18:0]   trem_q, trem_d;
  logic          done_q, done_d;
  logic          motor_q, motor_d;
  logic          brake_q, brake_d;
  logic          door_q, door_d;
  logic          tick, expire;

  function automatic logic is_timed(input logic [3:0] s);
    return (s == BRAKE) || (s == DOORS) || (s == DEPART);
  endfunction

  // A zero duration still occupies one full millisecond.
  function automatic logic [18:0] dur(input logic [3:0] s);
    logic [18:0] d;
    case (s)
      BRAKE:   d = 19'(T_BRAKE_MS);
      DOORS:   d = 19'(T_DOOR_MS);
      DEPART:  d = 19'(T_DEPART_MS);
      default: d = 19'd0;
    endcase
    return (d == 19'd0) ? 19'd1 : d;
  endfunction

  assign tick   = is_timed(state_q) && (presc_q == PMAX);
  assign expire = tick && (trem_q == 19'd1);

  always_comb begin
    state_d = state_q;
    if (bus.estop) begin
      state_d = ESTOP;
    end else begin
      case (state_q)
        IDLE:    if (bus.start)    state_d = ACCEL;
        ACCEL:   if (bus.speed_ok) state_d = CRUISE;
        CRUISE:  if (bus.station)  state_d = BRAKE;
        BRAKE:   if (expire)       state_d = DOORS;
        DOORS:   if (expire)       state_d = DEPART;
        DEPART:  if (expire)       state_d = bus.start ? ACCEL : IDLE;
        ESTOP:   if (bus.estop_ack) state_d = IDLE;
        default:                   state_d = ESTOP;
      endcase
    end
  end

  always_comb begin
    presc_d = '0;
    trem_d  = '0;
    done_d  = 1'b0;
    if (state_d != state_q) begin
      if (is_timed(state_d)) trem_d = dur(state_d);
      // estop steals the expiry edge, so no pulse in that case
      done_d = expire && !bus.estop;
    end else if (is_timed(state_q)) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      trem_d  = tick ? trem_q - 19'd1 : trem_q;
    end
    motor_d = (state_d == ACCEL) || (state_d == CRUISE);
    brake_d = (state_d == BRAKE) || (state_d == ESTOP) || (state_d == IDLE);
    door_d  = (state_d == DOORS);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      trem_q  <= '0;
      done_q  <= 1'b0;
      motor_q <= 1'b0;
      brake_q <= 1'b1;
      door_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      trem_q  <= trem_d;
      done_q  <= done_d;
      motor_q <= motor_d;
      brake_q <= brake_d;
      door_q  <= door_d;
    end
  end

  assign bus.present_state = state_q;
  assign bus.t_remaining   = trem_q;
  assign bus.timer_done    = done_q;
  assign bus.motor_en      = motor_q;
  assign bus.brake         = brake_q;
  assign bus.door_open     = door_q;

endmodule

// File: tb/tb_train_sequencer.sv
// Bench for train_sequencer: directed scenarios plus random stimulus checked
// against a cycles-since-entry reference model.
module tb_train_sequencer;
  localparam int K  = 4;
  localparam int TB = 3;
  localparam int TD = 2;
  localparam int TP = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  train_sequencer_if bus0 ();
  train_sequencer_if bus1 ();

  train_sequencer #(.CLKS_PER_MS(K), .T_BRAKE_MS(TB), .T_DOOR_MS(TD), .T_DEPART_MS(TP))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  train_sequencer #(.CLKS_PER_MS(K), .T_BRAKE_MS(TB), .T_DOOR_MS(0), .T_DEPART_MS(TP))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  int total = 0;
  int bad   = 0;

  // Reference model for dut0: state code and number of edges since entry.
  int m_st = 0;
  int m_c  = 0;
  bit m_done = 1'b0;

  function automatic int mdur(input int s);
    case (s)
      3: return TB;
      4: return TD;
      5: return TP;
      default: return 0;
    endcase
  endfunction

  function automatic bit mtimed(input int s);
    return (s >= 3) && (s <= 5);
  endfunction

  function automatic int mtrem();
    return mtimed(m_st) ? (mdur(m_st) - m_c / K) : 0;
  endfunction

  task automatic mstep(input bit s, input bit so, input bit sn, input bit es, input bit ea);
    bit exp;
    int nx;
    exp    = mtimed(m_st) && (m_c + 1 == mdur(m_st) * K);
    m_done = exp && !es;
    if (es) nx = 15;
    else case (m_st)
      0:  nx = s  ? 1 : 0;
      1:  nx = so ? 2 : 1;
      2:  nx = sn ? 3 : 2;
      3:  nx = exp ? 4 : 3;
      4:  nx = exp ? 5 : 4;
      5:  nx = exp ? (s ? 1 : 0) : 5;
      15: nx = ea ? 0 : 15;
      default: nx = 15;
    endcase
    m_c  = (nx != m_st) ? 0 : m_c + 1;
    m_st = nx;
  endtask

  task automatic cyc(input bit s, input bit so, input bit sn, input bit es, input bit ea);
    @(negedge clk);
    bus0.start = s; bus0.speed_ok = so; bus0.station = sn; bus0.estop = es; bus0.estop_ack = ea;
    bus1.start = s; bus1.speed_ok = so; bus1.station = sn; bus1.estop = es; bus1.estop_ack = ea;
    @(posedge clk);
    if (rst_n) mstep(s, so, sn, es, ea);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    m_st = 0; m_c = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++; if (bus0.present_state !== 4'b0000) begin bad++; $display("FAIL rst_state got=%b exp=0000", bus0.present_state); end
    total++; if (bus0.brake !== 1'b1) begin bad++; $display("FAIL rst_brake got=%b exp=1", bus0.brake); end
    total++; if (bus0.motor_en !== 1'b0 || bus0.door_open !== 1'b0) begin bad++; $display("FAIL rst_en got=%b%b exp=00", bus0.motor_en, bus0.door_open); end
    total++; if (bus0.t_remaining !== 19'd0 || bus0.timer_done !== 1'b0) begin bad++; $display("FAIL rst_timer got=%0d/%b exp=0/0", bus0.t_remaining, bus0.timer_done); end
    @(negedge clk); rst_n = 1'b1;
    cyc(1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 0, 1, 0, 0);
    repeat (5) cyc(0, 0, 0, 0, 0);
    total++; if (bus0.present_state !== 4'b0011) begin bad++; $display("FAIL pre_rst_brake got=%b exp=0011", bus0.present_state); end
    @(negedge clk); #2 rst_n = 1'b0; #1;
    m_st = 0; m_c = 0;
    total++; if (bus0.present_state !== 4'b0000 || bus0.t_remaining !== 19'd0) begin bad++; $display("FAIL async_rst got=%b/%0d exp=0000/0", bus0.present_state, bus0.t_remaining); end
    total++; if (bus0.brake !== 1'b1 || bus0.timer_done !== 1'b0) begin bad++; $display("FAIL async_rst_out got=%b/%b exp=1/0", bus0.brake, bus0.timer_done); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_normal_cycle();
    int cnt, pulses, d;
    pulses = 0;
    cyc(1, 0, 0, 0, 0);
    total++; if (bus0.present_state !== 4'b0001 || bus0.motor_en !== 1'b1) begin bad++; $display("FAIL accel got=%b/%b exp=0001/1", bus0.present_state, bus0.motor_en); end
    cyc(1, 1, 0, 0, 0);
    total++; if (bus0.present_state !== 4'b0010) begin bad++; $display("FAIL cruise got=%b exp=0010", bus0.present_state); end
    pulses += bus0.timer_done;
    cyc(1, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      d = (k == 0) ? TB : (k == 1) ? TD : TP;
      cnt = 0;
      while (bus0.present_state === 4'(3 + k) && cnt < 200) begin
        total++; if (bus0.t_remaining !== 19'(d - cnt / K)) begin bad++; $display("FAIL trem st=%0d cyc=%0d got=%0d exp=%0d", 3 + k, cnt, bus0.t_remaining, d - cnt / K); end
        if (k == 1) begin
          total++; if (bus0.door_open !== 1'b1) begin bad++; $display("FAIL door_open cyc=%0d got=%b exp=1", cnt, bus0.door_open); end
        end
        pulses += bus0.timer_done;
        cyc(1, 0, 0, 0, 0);
        cnt++;
      end
      total++; if (cnt != d * K) begin bad++; $display("FAIL dur st=%0d got=%0d exp=%0d", 3 + k, cnt, d * K); end
    end
    total++; if (bus0.present_state !== 4'b0001) begin bad++; $display("FAIL depart_to_accel got=%b exp=0001", bus0.present_state); end
    pulses += bus0.timer_done;
    cyc(1, 0, 0, 0, 0);
    pulses += bus0.timer_done;
    total++; if (pulses != 3) begin bad++; $display("FAIL done_pulses got=%0d exp=3", pulses); end
  endtask

  task automatic test_depart_no_start();
    int cnt;
    cyc(1, 1, 0, 0, 0); cyc(1, 0, 1, 0, 0);
    cnt = 0;
    while (bus0.present_state !== 4'b0101 && cnt < 100) begin cyc(1, 0, 0, 0, 0); cnt++; end
    total++; if (bus0.present_state !== 4'b0101) begin bad++; $display("FAIL reach_depart got=%b exp=0101", bus0.present_state); end
    cnt = 0;
    while (bus0.present_state === 4'b0101 && cnt < 100) begin
      total++; if (bus0.motor_en !== 1'b0) begin bad++; $display("FAIL depart_motor got=%b exp=0", bus0.motor_en); end
      cyc(0, 0, 0, 0, 0); cnt++;
    end
    total++; if (bus0.present_state !== 4'b0000 || bus0.motor_en !== 1'b0) begin bad++; $display("FAIL depart_idle got=%b/%b exp=0000/0", bus0.present_state, bus0.motor_en); end
    cyc(0, 0, 0, 0, 0);
    total++; if (bus0.present_state !== 4'b0000 || bus0.motor_en !== 1'b0) begin bad++; $display("FAIL idle_hold got=%b/%b exp=0000/0", bus0.present_state, bus0.motor_en); end
  endtask

  task automatic test_estop_on_expiry();
    int cnt;
    cyc(1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 0, 1, 0, 0);
    cnt = 0;
    while (bus0.present_state !== 4'b0100 && cnt < 100) begin cyc(0, 0, 0, 0, 0); cnt++; end
    repeat (TD * K - 1) cyc(0, 0, 0, 0, 0);
    total++; if (bus0.present_state !== 4'b0100 || bus0.t_remaining !== 19'd1) begin bad++; $display("FAIL doors_last got=%b/%0d exp=0100/1", bus0.present_state, bus0.t_remaining); end
    cyc(0, 0, 0, 1, 0);
    total++; if (bus0.present_state !== 4'b1111) begin bad++; $display("FAIL estop_state got=%b exp=1111", bus0.present_state); end
    total++; if (bus0.timer_done !== 1'b0 || bus0.door_open !== 1'b0) begin bad++; $display("FAIL estop_out got=%b/%b exp=0/0", bus0.timer_done, bus0.door_open); end
    total++; if (bus0.t_remaining !== 19'd0 || bus0.brake !== 1'b1) begin bad++; $display("FAIL estop_timer got=%0d/%b exp=0/1", bus0.t_remaining, bus0.brake); end
    repeat (3) cyc(0, 0, 0, 0, 0);
    total++; if (bus0.present_state !== 4'b1111) begin bad++; $display("FAIL estop_hold got=%b exp=1111", bus0.present_state); end
    cyc(0, 0, 0, 0, 1);
    total++; if (bus0.present_state !== 4'b0000) begin bad++; $display("FAIL estop_ack got=%b exp=0000", bus0.present_state); end
  endtask

  task automatic test_illegal_state();
    #1 force dut0.state_q = 4'b1010;
    #1 release dut0.state_q;
    m_st = 10; m_c = 0;
    cyc(0, 0, 0, 0, 0);
    total++; if (bus0.present_state !== 4'b1111 || bus0.brake !== 1'b1) begin bad++; $display("FAIL illegal got=%b/%b exp=1111/1", bus0.present_state, bus0.brake); end
    cyc(0, 0, 0, 0, 1);
    total++; if (bus0.present_state !== 4'b0000) begin bad++; $display("FAIL illegal_clear got=%b exp=0000", bus0.present_state); end
  endtask

  task automatic test_zero_duration();
    int cnt;
    do_reset();
    cyc(1, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0); cyc(0, 0, 1, 0, 0);
    cnt = 0;
    while (bus1.present_state !== 4'b0100 && cnt < 100) begin cyc(0, 0, 0, 0, 0); cnt++; end
    total++; if (bus1.present_state !== 4'b0100 || bus1.t_remaining !== 19'd1) begin bad++; $display("FAIL zero_load got=%b/%0d exp=0100/1", bus1.present_state, bus1.t_remaining); end
    cnt = 0;
    while (bus1.present_state === 4'b0100 && cnt < 100) begin cyc(0, 0, 0, 0, 0); cnt++; end
    total++; if (cnt != K) begin bad++; $display("FAIL zero_dur got=%0d exp=%0d", cnt, K); end
    total++; if (bus1.present_state !== 4'b0101) begin bad++; $display("FAIL zero_next got=%b exp=0101", bus1.present_state); end
  endtask

  task automatic test_random();
    bit s, so, sn, es, ea;
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      s  = ($urandom_range(0, 9) < 7);
      so = ($urandom_range(0, 9) < 3);
      sn = ($urandom_range(0, 9) < 2);
      es = ($urandom_range(0, 99) < 3);
      ea = ($urandom_range(0, 9) < 3);
      cyc(s, so, sn, es, ea);
      total++; if (bus0.present_state !== 4'(m_st)) begin bad++; $display("FAIL rnd_state i=%0d got=%b exp=%0d", i, bus0.present_state, m_st); end
      total++; if (bus0.t_remaining !== 19'(mtrem())) begin bad++; $display("FAIL rnd_trem i=%0d got=%0d exp=%0d", i, bus0.t_remaining, mtrem()); end
      total++; if (bus0.timer_done !== m_done) begin bad++; $display("FAIL rnd_done i=%0d got=%b exp=%b", i, bus0.timer_done, m_done); end
      total++; if ({bus0.motor_en, bus0.brake, bus0.door_open} !==
                   {(m_st == 1 || m_st == 2), (m_st == 0 || m_st == 3 || m_st == 15), (m_st == 4)}) begin
        bad++; $display("FAIL rnd_act i=%0d got=%b%b%b st=%0d", i, bus0.motor_en, bus0.brake, bus0.door_open, m_st);
      end
    end
  endtask

  initial begin
    bus0.start = 0; bus0.speed_ok = 0; bus0.station = 0; bus0.estop = 0; bus0.estop_ack = 0;
    bus1.start = 0; bus1.speed_ok = 0; bus1.station = 0; bus1.estop = 0; bus1.estop_ack = 0;
    test_reset();
    test_normal_cycle();
    test_depart_no_start();
    test_estop_on_expiry();
    test_illegal_state();
    test_zero_duration();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
